// File: rtl/s2_logic_cell.sv
// S-module logic cell: gated-select 4:1 mux feeding a D flip-flop with async active-low clear.
// The flop is the only state; out is always driven straight from it.
module s2_logic_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d,
    input  logic       A0,
    input  logic       B0,
    input  logic       A1,
    input  logic       B1,
    output logic       out
);

    logic       s0;
    logic       s1;
    logic [1:0] sel;
    logic       m;

    assign s1  = A1 & B1;
    assign s0  = A0 | B0;
    assign sel = {s1, s0};

    // Explicit case keeps unselected d bits out of the selected path.
    always_comb begin
        m = d[0];
        case (sel)
            2'b00:   m = d[0];
            2'b01:   m = d[1];
            2'b10:   m = d[2];
            2'b11:   m = d[3];
            default: m = d[0];
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            out <= RESET_VAL;
        else
            out <= m;
    end

endmodule

// File: tb/tb_s2_logic_cell.sv
// Directed bench for s2_logic_cell: clear behaviour, select gating, exhaustive mux sweep.
module tb_s2_logic_cell;

    logic       clk;
    logic       clr;
    logic [3:0] d;
    logic       A0, B0, A1, B1;
    logic       out;

    int checks = 0;
    int errors = 0;

    s2_logic_cell #(.RESET_VAL(1'b0)) dut (
        .clk(clk), .clr(clr), .d(d),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a vector on the falling edge, confirm out has not moved yet,
    // then confirm the registered value just after the next rising edge.
    task automatic apply_vec(input string name, input logic [3:0] dv,
                             input logic a1, input logic b1, input logic a0, input logic b0,
                             input logic exp);
        logic prev;
        @(negedge clk);
        prev = out;
        d = dv; A1 = a1; B1 = b1; A0 = a0; B0 = b0;
        #2;
        checks++;
        if (out !== prev) begin
            errors++;
            $display("FAIL %s_nocomb: out=%b required=%b", name, out, prev);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s: d=%b A1=%b B1=%b A0=%b B0=%b out=%b required=%b",
                     name, dv, a1, b1, a0, b0, out, exp);
        end
    endtask

    task automatic test_reset();
        d = 4'b0110; A1 = 1; B1 = 1; A0 = 1; B0 = 1;
        clr = 1'b1;
        #3 clr = 1'b0;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: out=%b required=0", out);
        end
        // d[3]=0 here, so also try a vector whose selected bit is 1
        for (int i = 0; i < 4; i++) begin
            if (i == 2) d = 4'b1111;
            @(posedge clk); #1;
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%b required=0", i, out);
            end
        end
        @(negedge clk);
        clr = 1'b1;
        d = 4'b1111;
        #2;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_before_edge: out=%b required=0", out);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_first_edge: out=%b required=1", out);
        end
    endtask

    task automatic test_directed();
        apply_vec("sel11_all_ones", 4'b1111, 1, 1, 1, 1, 1'b1);
        apply_vec("sel11_d3",       4'b0110, 1, 1, 1, 0, 1'b0);
        apply_vec("sel01_d1",       4'b0110, 0, 0, 1, 1, 1'b1);
        apply_vec("sel00_gated",    4'b0001, 1, 0, 0, 0, 1'b1);
        apply_vec("sel10_d2",       4'b0100, 1, 1, 0, 0, 1'b1);
        apply_vec("sel01_b0_only",  4'b1101, 0, 1, 0, 1, 1'b0);
    endtask

    task automatic test_exhaustive();
        logic [3:0] dv;
        logic [3:0] ab;
        logic [1:0] sel;
        for (int di = 0; di < 16; di++) begin
            for (int si = 0; si < 16; si++) begin
                dv  = di[3:0];
                ab  = si[3:0];                       // {A1,B1,A0,B0}
                sel = {ab[3] & ab[2], ab[1] | ab[0]};
                apply_vec("exhaustive", dv, ab[3], ab[2], ab[1], ab[0], dv[sel]);
            end
        end
    endtask

    task automatic test_unselected_x();
        apply_vec("x_unselected_sel00", 4'bxxx1, 0, 0, 0, 0, 1'b1);
        apply_vec("x_unselected_sel11", 4'b0xxx, 1, 1, 0, 1, 1'b0);
    endtask

    task automatic test_async_clear();
        apply_vec("preload_one", 4'b1111, 1, 1, 1, 1, 1'b1);
        @(negedge clk);
        #1 clr = 1'b0;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL async_clear_midcycle: out=%b required=0", out);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL async_clear_hold: out=%b required=0", out);
        end
        @(negedge clk);
        clr = 1'b1;
        d = 4'b1111; A1 = 0; B1 = 0; A0 = 0; B0 = 0;
        @(posedge clk); #1;
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL async_clear_release: out=%b required=1", out);
        end
    endtask

    task automatic test_back_to_back();
        apply_vec("b2b_0", 4'b1010, 0, 0, 0, 1, 1'b1);
        apply_vec("b2b_1", 4'b1010, 0, 0, 0, 0, 1'b0);
        apply_vec("b2b_2", 4'b1010, 1, 1, 1, 1, 1'b1);
        apply_vec("b2b_3", 4'b1010, 1, 1, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_unselected_x();
        test_async_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
